// File: rtl/data_mem.sv
// Data memory stage: byte-addressed word/byte store, combinational load, write-back mux.
// Latency: loads and data_out are combinational (0 cycles); stores commit on the sysclk rising edge.
// Backpressure: none, so every access completes in its own cycle and there is no stall path.
module data_mem #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 10
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [31:0] alu_result,
   input  logic        s1,
   input  logic [31:0] write_data,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic        mem_to_reg,
   output logic [31:0] data_out
);

   localparam int IDX_W = ADDR_W - 2;

   // Word-organised storage, little-endian byte lanes within each word
   logic [31:0] r_mem [DEPTH_WORDS];

   logic [IDX_W-1:0] w_idx;
   logic [1:0]       w_lane;
   logic [31:0]      w_word;
   logic [31:0]      w_wr_word;
   logic [31:0]      w_rd;

   // Upper address bits are dropped, so accesses wrap modulo the memory size
   assign w_idx  = alu_result[ADDR_W-1:2];
   assign w_lane = alu_result[1:0];
   assign w_word = r_mem[w_idx];

   // Build the word to store: full word, or the current word with one lane replaced
   always_comb begin
      w_wr_word = write_data;
      if (s1) begin
         w_wr_word = w_word;
         w_wr_word[{w_lane, 3'b000} +: 8] = write_data[7:0];
      end
   end

   // Load path: word read ignores lane bits, byte read zero-extends, no read gives zero
   always_comb begin
      w_rd = 32'h0;
      if (mem_read) begin
         if (s1) begin
            w_rd = {24'h0, w_word[{w_lane, 3'b000} +: 8]};
         end else begin
            w_rd = w_word;
         end
      end
   end

   assign data_out = mem_to_reg ? w_rd : alu_result;

   // Storage update: reset clears every word and overrides any store in the same cycle
   always_ff @(posedge sysclk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            r_mem[i] <= 32'h0;
         end
      end else if (mem_write) begin
         r_mem[w_idx] <= w_wr_word;
      end
   end

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed plan steps followed by randomized traffic.
// Reference is a flat byte array indexed by the wrapped byte address.
// data_out is sampled 1 time unit after inputs settle, away from the rising edge.
module tb_data_mem;

   localparam int DEPTH = 256;
   localparam int BYTES = 4 * DEPTH;

   logic        sysclk = 1'b0;
   logic        reset;
   logic [31:0] alu_result;
   logic        s1;
   logic [31:0] write_data;
   logic        mem_write;
   logic        mem_read;
   logic        mem_to_reg;
   logic [31:0] data_out;

   int tests = 0;
   int fails = 0;

   logic [7:0] mem_m [BYTES];

   data_mem #(.DEPTH_WORDS(DEPTH), .ADDR_W(10)) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .alu_result (alu_result),
      .s1         (s1),
      .write_data (write_data),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .mem_to_reg (mem_to_reg),
      .data_out   (data_out)
   );

   always #5 sysclk = ~sysclk;

   function automatic logic [31:0] model_out();
      int a, base;
      a = int'(alu_result % BYTES);
      base = a - (a % 4);
      if (!mem_to_reg) return alu_result;
      if (!mem_read) return 32'h0;
      if (s1) return {24'h0, mem_m[a]};
      return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
   endfunction

   task automatic set_in(input logic rst, input logic [31:0] addr, input logic sz,
                         input logic [31:0] wd, input logic mw, input logic mr, input logic m2r);
      reset = rst; alu_result = addr; s1 = sz; write_data = wd;
      mem_write = mw; mem_read = mr; mem_to_reg = m2r;
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] exp);
      tests++;
      assert (data_out === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
      end
   endtask

   // One rising edge; the model applies the same rules to the inputs held across it
   task automatic tick();
      int a, base;
      a = int'(alu_result % BYTES);
      base = a - (a % 4);
      @(posedge sysclk);
      if (reset) begin
         for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h0;
      end else if (mem_write) begin
         if (s1) mem_m[a] = write_data[7:0];
         else for (int k = 0; k < 4; k++) mem_m[base+k] = write_data[8*k +: 8];
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < BYTES; i++) mem_m[i] = 8'hxx;

      // Reset, then read from a cleared location
      set_in(1, 32'h10, 0, 32'h0, 0, 0, 0);
      tick();
      set_in(0, 32'h10, 0, 32'h0, 0, 1, 1);
      check("reset_read", 32'h0);

      // Word store / load and the aliased unaligned word read
      set_in(0, 32'h0, 0, 32'h5, 1, 0, 0);
      tick();
      set_in(0, 32'h0, 0, 32'h0, 0, 1, 1);
      check("word_load", 32'h5);
      set_in(0, 32'h1, 0, 32'h0, 0, 1, 1);
      check("word_alias", 32'h5);

      // Write-back mux
      set_in(0, 32'h1234ABCD, 0, 32'h0, 0, 1, 0);
      check("wb_alu", 32'h1234ABCD);
      set_in(0, 32'h0, 0, 32'h0, 0, 0, 1);
      check("wb_noread", 32'h0);

      // Byte store into an existing word
      set_in(0, 32'h8, 0, 32'h11223344, 1, 0, 0);
      tick();
      set_in(0, 32'h9, 1, 32'hFFFFFFAA, 1, 0, 0);
      tick();
      set_in(0, 32'h8, 0, 32'h0, 0, 1, 1);
      check("byte_merge", 32'h1122AA44);
      set_in(0, 32'hB, 1, 32'h0, 0, 1, 1);
      check("byte_load", 32'h00000011);
      set_in(0, 32'h9, 1, 32'h0, 0, 1, 1);
      check("byte_load_lane1", 32'h000000AA);

      // No store when mem_write is low
      set_in(0, 32'h4, 0, 32'h6, 0, 0, 0);
      tick();
      set_in(0, 32'h4, 0, 32'h0, 0, 1, 1);
      check("no_write", 32'h0);

      // Same-address read during write: old value before the edge, new after
      set_in(0, 32'h8, 0, 32'hCAFEF00D, 1, 1, 1);
      check("rw_before", 32'h1122AA44);
      tick();
      check("rw_after", 32'hCAFEF00D);

      // Address wrap
      set_in(0, 32'(BYTES + 4), 0, 32'hDEADBEEF, 1, 0, 0);
      tick();
      set_in(0, 32'h4, 0, 32'h0, 0, 1, 1);
      check("wrap", 32'hDEADBEEF);

      // Reset with a simultaneous store: store suppressed, all words zero
      set_in(1, 32'h4, 0, 32'h12345678, 1, 1, 1);
      tick();
      for (int w = 0; w < DEPTH; w++) begin
         set_in(0, 32'(4 * w), 0, 32'h0, 0, 1, 1);
         check("reset_clear", 32'h0);
      end

      // Randomized traffic over a small window so stores and loads collide often
      for (int n = 0; n < 600; n++) begin
         logic [31:0] addr;
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = {addr[31:10] & {22{addr[0]}}, 4'h0, addr[5:0]};
         set_in(($urandom_range(0, 99) == 0), addr, 1'($urandom), $urandom,
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
         check("rand_pre", model_out());
         tick();
         check("rand_post", model_out());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Data memory stage of the single-cycle 32-bit CPU datapath.
- Stores words or bytes at the address produced by the ALU, and supports word or byte loads.
- Contains the write-back mux: it selects between loaded memory data and the ALU result.
- Sits between the ALU and the register-file write port.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; must be a power of two.
- ADDR_W, 10, byte-address bits used (log2(DEPTH_WORDS)+2); higher address bits are ignored.

Ports:
- sysclk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_result  input  32  byte address for memory access; also the write-back value when mem_to_reg=0.
- s1  input  1  access size: 0 = word (32-bit), 1 = byte (8-bit).
- write_data  input  32  store data; byte store uses write_data[7:0].
- mem_write  input  1  store enable, sampled on rising edge.
- mem_read  input  1  load enable (combinational).
- mem_to_reg  input  1  write-back select: 1 = memory load data, 0 = alu_result.
- data_out  output  32  write-back value to the register file.

Behaviour:
- One clock (sysclk); reset is synchronous and active-high.
- Storage is DEPTH_WORDS x 32-bit words, little-endian, byte-addressed by alu_result[ADDR_W-1:0]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Word index = addr[ADDR_W-1:2]; byte lane = addr[1:0].
- Word access (s1=0): addr[1:0] is ignored (forced alignment). Address 1 therefore aliases word 0.
- Reset: on a rising edge with reset=1, every storage word is cleared to 0 and any store in that cycle is suppressed. data_out is combinational, so it reflects the cleared memory after that edge.
- Store on rising edge with reset=0 and mem_write=1:
  - s1=0: mem[word] <= write_data.
  - s1=1: only byte lane addr[1:0] of mem[word] is replaced with write_data[7:0]; the other three bytes are unchanged.
- mem_write=0: memory is unchanged.
- Load is combinational (zero latency from address/control change):
  - mem_read=1, s1=0: rd = mem[word].
  - mem_read=1, s1=1: rd = {24'h0, selected byte} (zero-extended).
  - mem_read=0: rd = 32'h0.
- data_out = mem_to_reg ? rd : alu_result. This is purely combinational; no register on the output.
- Simultaneous mem_read and mem_write to the same address: before the edge data_out shows the old contents; after the edge it shows the newly written data. No bypass.
- mem_read and mem_write are independent; both high is legal.
- Control inputs that are X/unknown are not required to be handled. The bench drives defined values.
- Memory contents are 0 after reset. Contents before the first reset are undefined; simulation may initialise them to 0.

Test Plan:
- Reset: reset=1 for one edge, then mem_read=1, mem_to_reg=1, s1=0, alu_result=0x10 -> data_out=0x00000000.
- Word store/load: alu_result=0, write_data=0x5, mem_write=1, rising edge; then mem_write=0, mem_read=1, mem_to_reg=1 -> data_out=0x00000005. With alu_result=1 (aliases word 0) -> data_out=0x00000005.
- Write-back mux:
  - mem_to_reg=0, alu_result=0x1234ABCD -> data_out=0x1234ABCD regardless of memory.
  - mem_to_reg=1, mem_read=0 -> data_out=0x00000000.
- Byte store/load:
  - Word store 0x11223344 at addr 8, then byte store s1=1, addr 0x9, write_data=0xFFFFFFAA.
  - Word load at addr 8 -> 0x1122AA44.
  - Byte load at addr 0xB -> 0x00000011.
- Write with mem_write=0: alu_result=4, write_data=0x6, mem_write=0, edge -> a load at addr 4 still returns its previous value (0 after reset).
- Wrap/reset mid-operation:
  - Store 0xDEADBEEF at addr 4*DEPTH_WORDS+4; a load at addr 4 -> 0xDEADBEEF.
  - Assert reset together with mem_write=1 on one edge -> the store is suppressed and every location reads 0.
